// File: rtl/timer_pkg.sv
// Shared constants for the coco_timer countdown timers: register map, CTRL layout,
// FSM encoding and bus base addresses.
package timer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t LOAD = 2'd1;
  localparam state_t CNT  = 2'd2;
  localparam state_t INT  = 2'd3;

  localparam logic [1:0] CTRL_OFF   = 2'd0;
  localparam logic [1:0] PRESET_OFF = 2'd1;
  localparam logic [1:0] COUNT_OFF  = 2'd2;

  localparam int unsigned EN      = 0;
  localparam int unsigned MODE_LO = 1;
  localparam int unsigned MODE_HI = 2;
  localparam int unsigned IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  localparam logic [31:0] TM0_BASE = 32'h0000_7f00;
  localparam logic [31:0] TM1_BASE = 32'h0000_7f10;

  // Only 01 reloads; 1x falls back to one-shot behaviour.
  function automatic logic is_reload(input logic [1:0] mode);
    return mode == MODE_RELOAD;
  endfunction

endpackage

// File: rtl/coco_timer.sv
// Memory-mapped countdown timer with CTRL/PRESET/COUNT registers and a registered
// interrupt output gated by CTRL.IM.
module coco_timer
  import timer_pkg::*;
#(
  parameter logic [31:0] PRESET_RST = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  state_t      state_q, state_d;
  logic        en_q, en_d;
  logic [1:0]  mode_q, mode_d;
  logic        im_q, im_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        flag_q, flag_d;
  logic        irq_q;
  logic        wr_ctrl, wr_preset;

  assign wr_ctrl   = we && (addr == CTRL_OFF);
  assign wr_preset = we && (addr == PRESET_OFF);

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    mode_d   = mode_q;
    im_d     = im_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;

    if (wr_preset) begin
      preset_d = wdata;
    end
    if (wr_ctrl || wr_preset) begin
      flag_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (en_q) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!en_q) begin
          state_d = IDLE;
        end else if (count_q <= 32'd1) begin
          count_d = 32'd0;
          flag_d  = 1'b1;  // set beats a same-cycle bus clear
          state_d = INT;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      INT: begin
        state_d = IDLE;
        if (is_reload(mode_q)) begin
          flag_d = 1'b0;
        end else begin
          en_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bus write to CTRL overrides the FSM's one-shot EN clear.
    if (wr_ctrl) begin
      en_d   = wdata[EN];
      mode_d = wdata[MODE_HI:MODE_LO];
      im_d   = wdata[IM];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      en_q     <= 1'b0;
      mode_q   <= MODE_ONESHOT;
      im_q     <= 1'b0;
      preset_q <= PRESET_RST;
      count_q  <= 32'd0;
      flag_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
      irq_q    <= im_d & flag_d;
    end
  end

  assign irq = irq_q;

  always_comb begin
    rdata = 32'd0;
    case (addr)
      CTRL_OFF:   rdata = {28'd0, im_q, mode_q, en_q};
      PRESET_OFF: rdata = preset_q;
      COUNT_OFF:  rdata = count_q;
      default:    rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_coco_timer.sv
// Directed self-checking bench for coco_timer: reset, one-shot, auto-reload, mask,
// disable/re-enable, CTRL write collision and asynchronous reset mid-count.
module tb_coco_timer;
  import timer_pkg::*;

  localparam logic [31:0] P_RST = 32'h0000_0abc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  addr = 2'd0;
  logic        we = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  coco_timer #(.PRESET_RST(P_RST)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    check(tag, {31'd0, irq}, {31'd0, exp});
  endtask

  // Write lands on the next rising edge; returns 1 time unit after it.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Reset and idle
    tick(2);
    chk_reg("rst_ctrl", CTRL_OFF, 32'd0);
    chk_reg("rst_preset", PRESET_OFF, P_RST);
    chk_reg("rst_count", COUNT_OFF, 32'd0);
    chk_irq("rst_irq", 1'b0);
    @(negedge clk);
    reset = 1'b0;
    wr(COUNT_OFF, 32'd5);
    chk_reg("count_ro", COUNT_OFF, 32'd0);
    wr(2'd3, 32'hffff_ffff);
    chk_reg("reserved", 2'd3, 32'd0);
    chk_reg("reserved_ctrl", CTRL_OFF, 32'd0);

    // One-shot, PRESET = 3
    wr(PRESET_OFF, 32'd3);
    chk_reg("os_preset", PRESET_OFF, 32'd3);
    wr(CTRL_OFF, 32'h9);
    chk_reg("os_ctrl_e0", CTRL_OFF, 32'h9);
    tick(1);
    chk_reg("os_count_e1", COUNT_OFF, 32'd0);
    chk_irq("os_irq_e1", 1'b0);
    for (int k = 2; k <= 5; k++) begin
      tick(1);
      chk_reg($sformatf("os_count_e%0d", k), COUNT_OFF, 32'(5 - k));
      chk_irq($sformatf("os_irq_e%0d", k), k == 5);
    end
    tick(1);
    chk_reg("os_ctrl_e6", CTRL_OFF, 32'h8);
    chk_irq("os_irq_e6", 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk_irq($sformatf("os_irq_hold%0d", i), 1'b1);
    end
    wr(PRESET_OFF, 32'd3);
    chk_irq("os_irq_clr", 1'b0);

    // Auto-reload, PRESET = 2: pulses at E4, E9, E14, E19
    wr(PRESET_OFF, 32'd2);
    wr(CTRL_OFF, 32'hb);
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      chk_irq($sformatf("ar_irq_e%0d", k), (k >= 4) && ((k - 4) % 5 == 0));
    end
    wr(CTRL_OFF, 32'h0);
    tick(3);
    chk_irq("ar_stop_irq", 1'b0);
    chk_reg("ar_stop_ctrl", CTRL_OFF, 32'h0);

    // Masked one-shot, PRESET = 1
    wr(PRESET_OFF, 32'd1);
    wr(CTRL_OFF, 32'h1);
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      chk_irq($sformatf("mask_irq_e%0d", k), 1'b0);
      if (k == 2) chk_reg("mask_count_e2", COUNT_OFF, 32'd1);
      if (k == 3) chk_reg("mask_count_e3", COUNT_OFF, 32'd0);
    end
    chk_reg("mask_ctrl_done", CTRL_OFF, 32'h0);
    wr(CTRL_OFF, 32'h8);
    chk_irq("mask_unmask", 1'b0);
    tick(2);
    chk_irq("mask_unmask_late", 1'b0);

    // Disable mid-count, PRESET = 100
    wr(PRESET_OFF, 32'd100);
    wr(CTRL_OFF, 32'h1);
    tick(10);
    chk_reg("dis_count_e10", COUNT_OFF, 32'd92);
    wr(CTRL_OFF, 32'h0);
    chk_reg("dis_count_e11", COUNT_OFF, 32'd91);
    tick(3);
    chk_reg("dis_frozen", COUNT_OFF, 32'd91);
    wr(CTRL_OFF, 32'h1);
    tick(1);
    chk_reg("reen_load", COUNT_OFF, 32'd91);
    tick(1);
    chk_reg("reen_reload", COUNT_OFF, 32'd100);
    tick(1);
    chk_reg("reen_dec", COUNT_OFF, 32'd99);
    wr(CTRL_OFF, 32'h0);
    tick(2);

    // Collision: CTRL write on the edge that leaves INT
    wr(PRESET_OFF, 32'd2);
    wr(CTRL_OFF, 32'h9);
    tick(4);
    chk_irq("col_irq_e4", 1'b1);
    wr(CTRL_OFF, 32'h3);
    chk_reg("col_ctrl", CTRL_OFF, 32'h3);
    chk_irq("col_irq", 1'b0);
    tick(1);
    chk_reg("col_count_load", COUNT_OFF, 32'd0);
    tick(1);
    chk_reg("col_count_restart", COUNT_OFF, 32'd2);

    // Asynchronous reset while irq is held high
    wr(CTRL_OFF, 32'h0);
    tick(2);
    wr(CTRL_OFF, 32'h9);
    tick(6);
    chk_irq("ar_pre_irq", 1'b1);
    #2 reset = 1'b1;
    #1;
    chk_irq("async_irq", 1'b0);
    chk_reg("async_ctrl_a", CTRL_OFF, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Asynchronous reset mid-count
    wr(PRESET_OFF, 32'd50);
    wr(CTRL_OFF, 32'h1);
    tick(5);
    chk_reg("mid_count", COUNT_OFF, 32'd47);
    #2 reset = 1'b1;
    #1;
    chk_reg("async_count", COUNT_OFF, 32'd0);
    chk_reg("async_ctrl", CTRL_OFF, 32'd0);
    chk_reg("async_preset", PRESET_OFF, P_RST);
    chk_irq("async_irq_b", 1'b0);
    @(negedge clk);
    reset = 1'b0;
    tick(3);
    chk_reg("post_rst_count", COUNT_OFF, 32'd0);
    chk_reg("post_rst_ctrl", CTRL_OFF, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/coco_timer.md
# coco_timer

Memory-mapped countdown timer on the M-stage data bus, directly downstream of the CPU datapath's data-memory port. Two instances sit at 0x0000_7F00 and 0x0000_7F10. Each holds three word registers: CTRL, PRESET and COUNT. Its interrupt output feeds one bit of CP0 HWInt (TM0_IRQ / TM1_IRQ).

## Interface
Parameters:
- `PRESET_RST`, default 32'h0, reset value of PRESET.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `addr`  in  2  word offset within the block (bus addr[3:2]): 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = reserved.
- `we`  in  1  full-word write strobe. The bus only issues word writes here; partial writes raise an exception upstream.
- `wdata`  in  32  write data.
- `rdata`  out  32  combinational read data for `addr`.
- `irq`  out  1  registered interrupt request, equal to CTRL.IM & irq_flag.

## Operation
- CTRL fields:
  - [0] EN, count enable.
  - [2:1] MODE: 00 = one-shot, 01 = auto-reload, 1x = treated as 00.
  - [3] IM, interrupt mask.
  - [31:4] read as 0 and are not stored.
- PRESET is 32-bit read/write. COUNT is read-only; writes to offset 2 or 3 are ignored.
- Reads:
  - offset 0 returns {28'b0, CTRL[3:0]}.
  - offset 1 returns PRESET.
  - offset 2 returns COUNT.
  - offset 3 returns 0.
- State machine (reset state IDLE):
  - IDLE: if EN = 1, go to LOAD. Otherwise stay; COUNT holds.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - If EN = 0, go to IDLE; COUNT holds.
    - Else if COUNT <= 1: COUNT <= 0, irq_flag <= 1, go to INT.
    - Else COUNT <= COUNT - 1.
  - INT, mode 00: EN <= 0; irq_flag stays 1; go to IDLE.
  - INT, mode 01: irq_flag <= 0; go to IDLE. EN is still 1, so the timer reloads and restarts.
- irq_flag is cleared by any bus write to CTRL or PRESET.
- Simultaneous events:
  - A bus write to CTRL in the same cycle the FSM clears EN (INT, mode 00): the bus value wins.
  - A bus write in the same cycle irq_flag is set (CNT→INT): the set wins.
- PRESET = 0 or 1: after LOAD, one CNT cycle, then INT.
- Writing PRESET while in CNT does not change the running COUNT; the new value takes effect at the next LOAD.
- Arithmetic is unsigned 32-bit. COUNT never wraps below 0.
- Reset values: CTRL = 0, PRESET = PRESET_RST, COUNT = 0, irq_flag = 0, state IDLE, so irq = 0. `rdata` follows `addr` combinationally during reset.
- Reset asserted mid-count aborts immediately. After release the timer idles until EN is written again.

## Timing
- Reads have zero latency, combinational from `addr` and the registers.
- Writes are visible on `rdata` the cycle after the write edge.
- Counting, with edges numbered from the edge E0 that writes EN = 1:
  - E1: state is LOAD.
  - E2: COUNT = PRESET.
  - Each later edge decrements COUNT by 1.
  - With PRESET = N ≥ 2, the INT state and `irq` = 1 occur at edge E(N+2).
- Mode 01 period is N + 3 cycles, from one irq assertion to the next. `irq` is high for exactly 1 cycle in mode 01.
- Mode 00: `irq` stays high until a CTRL or PRESET write.
- `irq` is registered, with no combinational path from `we`. Toggling IM affects `irq` on the next cycle.

## Structure
- Shared package `timer_pkg` holds:
  - state encoding (IDLE, LOAD, CNT, INT);
  - offsets CTRL_OFF = 0, PRESET_OFF = 1, COUNT_OFF = 2;
  - CTRL bit indices EN, MODE_LO, MODE_HI, IM;
  - MODE_ONESHOT = 2'b00, MODE_RELOAD = 2'b01;
  - base addresses TM0_BASE = 32'h7F00 and TM1_BASE = 32'h7F10, which the bridge also imports.
- Single flat module; no sub-module is warranted.

## Test plan
- Reset then idle: reset asserted mid-cycle → all three reads return 0 (PRESET returns PRESET_RST) and `irq` = 0 asynchronously; writing COUNT = 5 → COUNT still reads 0.
- One-shot: write PRESET = 3, then CTRL = 4'b1001 → COUNT reads 3, 2, 1, 0 at E2 to E5. `irq` rises at E5. CTRL reads 4'b1000 from E6. `irq` stays 1 for 10 more cycles, then clears one cycle after a PRESET write.
- Auto-reload: PRESET = 2, CTRL = 4'b1011 → `irq` pulses for 1 cycle every 5 cycles over 4 periods.
- Mask: one-shot with IM = 0 and PRESET = 1 → `irq` never rises. Then write CTRL = 4'b1000 → `irq` stays 0, because the write clears irq_flag.
- Disable mid-count: PRESET = 100; after 10 CNT cycles write CTRL = 0 → COUNT freezes at 91. Re-enable → COUNT reloads to 100.
- Collision: during one-shot, at the INT edge write CTRL = 4'b0011 → CTRL reads 4'b0011 (bus wins), `irq` = 0 because IM = 0, and the timer restarts through LOAD.
